// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for a 5-stage pipeline with I/D caches: cache-miss stalls,
// load-use bubbles, taken-branch flushes, HALT. `define STALL_CNT_EN adds stall counters.
module pipe_hazard_ctrl #(
  parameter int REG_W            = 3,
  parameter int NOP_ON_RESET_CYC = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_imem_stall,
  input  logic             i_dmem_stall,
  input  logic [REG_W-1:0] i_id_rs,
  input  logic [REG_W-1:0] i_id_rt,
  input  logic             i_id_use_rs,
  input  logic             i_id_use_rt,
  input  logic             i_ex_memread,
  input  logic [REG_W-1:0] i_ex_rd,
  input  logic             i_ex_br_taken,
  input  logic             i_wb_halt,
  output logic             o_pc_en,
  output logic             o_pc_redirect,
  output logic             o_ifid_en,
  output logic             o_ifid_nop,
  output logic             o_idex_en,
  output logic             o_idex_nop,
  output logic             o_exmem_en,
  output logic             o_memwb_en,
  output logic             o_halted
`ifdef STALL_CNT_EN
  ,
  output logic [15:0]      o_dstall_cnt,
  output logic [15:0]      o_istall_cnt
`endif
);

  typedef enum logic [1:0] {S_RUN, S_DWAIT, S_IWAIT, S_HALT} state_t;

  localparam int NC_W = (NOP_ON_RESET_CYC > 0) ? $clog2(NOP_ON_RESET_CYC + 1) : 1;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_flush_pend;
  logic              w_flush_nxt;
  logic [NC_W-1:0]   r_nop_cnt;
  logic              w_lu;

  // Register 0 is deliberately not exempt from load-use detection.
  assign w_lu = i_ex_memread &
                ((i_id_use_rs & (i_id_rs == i_ex_rd)) |
                 (i_id_use_rt & (i_id_rt == i_ex_rd)));

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= S_RUN;
      r_flush_pend <= 1'b0;
      r_nop_cnt    <= NC_W'(NOP_ON_RESET_CYC);
    end else begin
      r_state      <= w_state_nxt;
      r_flush_pend <= w_flush_nxt;
      if (r_nop_cnt != '0) r_nop_cnt <= r_nop_cnt - 1'b1;
    end
  end

  // NOTE: every output and next-state signal gets a default first, so no path
  // through this block can infer a latch.
  always_comb begin
    o_pc_en       = 1'b1;
    o_pc_redirect = 1'b0;
    o_ifid_en     = 1'b1;
    o_ifid_nop    = 1'b0;
    o_idex_en     = 1'b1;
    o_idex_nop    = 1'b0;
    o_exmem_en    = 1'b1;
    o_memwb_en    = 1'b1;
    o_halted      = 1'b0;
    w_state_nxt   = i_imem_stall ? S_IWAIT : S_RUN;
    w_flush_nxt   = r_flush_pend;

    if (i_rst) begin
      {o_pc_en, o_ifid_en, o_idex_en, o_exmem_en, o_memwb_en} = '0;
      o_ifid_nop  = 1'b1;
      o_idex_nop  = 1'b1;
      w_state_nxt = S_RUN;
      w_flush_nxt = 1'b0;
    end else if (r_state == S_HALT) begin
      {o_pc_en, o_ifid_en, o_idex_en, o_exmem_en, o_memwb_en} = '0;
      o_halted    = 1'b1;
      w_state_nxt = S_HALT;
    end else if (i_wb_halt) begin
      {o_pc_en, o_ifid_en, o_idex_en, o_exmem_en, o_memwb_en} = '0;
      w_state_nxt = S_HALT;
    end else if (i_dmem_stall) begin
      // The whole pipe freezes, so a branch sitting in EX is simply held.
      {o_pc_en, o_ifid_en, o_idex_en, o_exmem_en, o_memwb_en} = '0;
      w_state_nxt = S_DWAIT;
    end else if (i_ex_br_taken) begin
      o_ifid_nop    = 1'b1;
      o_idex_nop    = 1'b1;
      o_pc_redirect = ~i_imem_stall;
      o_pc_en       = ~i_imem_stall;
      w_flush_nxt   = i_imem_stall;
    end else if (w_lu) begin
      o_pc_en    = 1'b0;
      o_ifid_en  = 1'b0;
      o_idex_nop = 1'b1;
    end else if (i_imem_stall) begin
      o_pc_en    = 1'b0;
      o_ifid_nop = 1'b1;
    end else if (r_flush_pend) begin
      // Redirect deferred by an I-miss: issue it now, fetched word is wrong-path.
      o_pc_redirect = 1'b1;
      o_ifid_nop    = 1'b1;
      w_flush_nxt   = 1'b0;
    end

    if (!i_rst && r_nop_cnt != '0) o_ifid_nop = 1'b1;
  end

`ifdef STALL_CNT_EN
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_dstall_cnt <= '0;
      o_istall_cnt <= '0;
    end else begin
      if (r_state == S_DWAIT && o_dstall_cnt != 16'hFFFF) o_dstall_cnt <= o_dstall_cnt + 16'd1;
      if (r_state == S_IWAIT && o_istall_cnt != 16'hFFFF) o_istall_cnt <= o_istall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed test-plan steps followed by random stimulus,
// each cycle compared against a behavioural model of the sequencing rules.
module tb_pipe_hazard_ctrl;
  localparam int REG_W = 3;
  localparam int NRC   = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst, imem_stall, dmem_stall, id_use_rs, id_use_rt;
  logic             ex_memread, ex_br_taken, wb_halt;
  logic [REG_W-1:0] id_rs, id_rt, ex_rd;
  logic             pc_en, pc_redirect, ifid_en, ifid_nop, idex_en, idex_nop;
  logic             exmem_en, memwb_en, halted;
`ifdef STALL_CNT_EN
  logic [15:0]      dstall_cnt, istall_cnt;
`endif

  pipe_hazard_ctrl #(.REG_W(REG_W), .NOP_ON_RESET_CYC(NRC)) dut (
    .i_clk(clk), .i_rst(rst), .i_imem_stall(imem_stall), .i_dmem_stall(dmem_stall),
    .i_id_rs(id_rs), .i_id_rt(id_rt), .i_id_use_rs(id_use_rs), .i_id_use_rt(id_use_rt),
    .i_ex_memread(ex_memread), .i_ex_rd(ex_rd), .i_ex_br_taken(ex_br_taken),
    .i_wb_halt(wb_halt),
    .o_pc_en(pc_en), .o_pc_redirect(pc_redirect), .o_ifid_en(ifid_en),
    .o_ifid_nop(ifid_nop), .o_idex_en(idex_en), .o_idex_nop(idex_nop),
    .o_exmem_en(exmem_en), .o_memwb_en(memwb_en), .o_halted(halted)
`ifdef STALL_CNT_EN
    , .o_dstall_cnt(dstall_cnt), .o_istall_cnt(istall_cnt)
`endif
  );

  int vectors     = 0;
  int miscompares = 0;

  // Model: what the pipe is currently waiting on, plus the deferred redirect.
  bit m_halted, m_in_dwait, m_in_iwait, m_redirect_owed;
  int m_nop_left, m_dcycles, m_icycles;

  // Expected bits: {pc_en, pc_redirect, ifid_en, ifid_nop, idex_en, idex_nop, exmem_en, memwb_en, halted}
  function automatic logic [8:0] model_out();
    bit pe, pr, fe, fn, de, dn, xe, we, h;
    bit uses_load;
    uses_load = ex_memread && ((id_use_rs && id_rs == ex_rd) || (id_use_rt && id_rt == ex_rd));
    {pe, pr, fe, fn, de, dn, xe, we, h} = 9'b101010110;
    if (rst)                   {pe, pr, fe, fn, de, dn, xe, we, h} = 9'b000101000;
    else if (m_halted)         {pe, pr, fe, fn, de, dn, xe, we, h} = 9'b000000001;
    else if (wb_halt)          {pe, pr, fe, fn, de, dn, xe, we, h} = 9'b000000000;
    else if (dmem_stall)       {pe, pr, fe, fn, de, dn, xe, we, h} = 9'b000000000;
    else if (ex_br_taken) begin
      fn = 1; dn = 1; pe = !imem_stall; pr = !imem_stall;
    end
    else if (uses_load)        begin pe = 0; fe = 0; dn = 1; end
    else if (imem_stall)       begin pe = 0; fn = 1; end
    else if (m_redirect_owed)  begin pr = 1; fn = 1; end
    if (!rst && m_nop_left > 0) fn = 1;
    return {pe, pr, fe, fn, de, dn, xe, we, h};
  endfunction

  task automatic model_step();
    bit uses_load;
    uses_load = ex_memread && ((id_use_rs && id_rs == ex_rd) || (id_use_rt && id_rt == ex_rd));
    if (rst) begin
      m_halted = 0; m_in_dwait = 0; m_in_iwait = 0; m_redirect_owed = 0;
      m_nop_left = NRC; m_dcycles = 0; m_icycles = 0;
      return;
    end
    if (m_in_dwait && m_dcycles < 65535) m_dcycles++;
    if (m_in_iwait && m_icycles < 65535) m_icycles++;
    if (m_nop_left > 0) m_nop_left--;
    if (m_halted) return;
    m_in_dwait = 0;
    m_in_iwait = 0;
    if (wb_halt) m_halted = 1;
    else if (dmem_stall) m_in_dwait = 1;
    else begin
      m_in_iwait = imem_stall;
      if (ex_br_taken) m_redirect_owed = imem_stall;
      else if (!uses_load && !imem_stall) m_redirect_owed = 0;
    end
  endtask

  task automatic apply(input string tag, input bit r, im, dm, br, wh, mr, urs, urt,
                       input logic [REG_W-1:0] rs, rt, rd);
    logic [8:0] exp_v, obs_v;
    @(negedge clk);
    rst = r; imem_stall = im; dmem_stall = dm; ex_br_taken = br; wb_halt = wh;
    ex_memread = mr; id_use_rs = urs; id_use_rt = urt; id_rs = rs; id_rt = rt; ex_rd = rd;
    #1;
    exp_v = model_out();
    obs_v = {pc_en, pc_redirect, ifid_en, ifid_nop, idex_en, idex_nop, exmem_en, memwb_en, halted};
    vectors++;
    assert (obs_v === exp_v) else begin
      miscompares++;
      $error("FAIL %s observed=%b expected=%b", tag, obs_v, exp_v);
    end
`ifdef STALL_CNT_EN
    vectors++;
    assert (dstall_cnt === 16'(m_dcycles) && istall_cnt === 16'(m_icycles)) else begin
      miscompares++;
      $error("FAIL %s_cnt observed=%0d/%0d expected=%0d/%0d", tag, dstall_cnt, istall_cnt,
             m_dcycles, m_icycles);
    end
`endif
    model_step();
  endtask

  initial begin
    // Reset held two cycles, then the forced-nop cycle, then free running.
    apply("rst0",     1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    apply("rst1",     1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    apply("rel_nop",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    apply("normal",   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // Load-use bubble lasts exactly one cycle.
    apply("lu_rs",    0, 0, 0, 0, 0, 1, 1, 0, 3, 1, 3);
    apply("lu_after", 0, 0, 0, 0, 0, 0, 1, 0, 3, 1, 3);
    apply("lu_rt_r0", 0, 0, 0, 0, 0, 1, 0, 1, 5, 0, 0);
    apply("lu_unused",0, 0, 0, 0, 0, 1, 0, 0, 3, 3, 3);
    // D-cache miss for four cycles.
    for (int i = 0; i < 4; i++) apply("dstall", 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    apply("d_exit",   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // Branch under an I-miss: redirect deferred until the miss clears.
    for (int i = 0; i < 3; i++) apply("br_imiss", 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    apply("br_deferred", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    apply("br_done",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // D-stall beats a branch; the held branch flushes when the stall falls.
    apply("d_br0",    0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    apply("d_br1",    0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    apply("d_br_fl",  0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    apply("post_fl",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // HALT retires and the core ignores everything until reset.
    apply("halt_in",  0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    apply("halted0",  0, 1, 1, 1, 0, 1, 1, 1, 2, 2, 2);
    apply("halted1",  0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0);
    apply("rst2",     1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    apply("rel2",     0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 600; i++) begin
      apply("rand",
            bit'($urandom_range(0, 99) < 3),
            bit'($urandom_range(0, 99) < 25),
            bit'($urandom_range(0, 99) < 15),
            bit'($urandom_range(0, 99) < 15),
            bit'($urandom_range(0, 99) < 2),
            bit'($urandom_range(0, 99) < 40),
            bit'($urandom_range(0, 1)),
            bit'($urandom_range(0, 1)),
            REG_W'($urandom_range(0, 3)),
            REG_W'($urandom_range(0, 3)),
            REG_W'($urandom_range(0, 3)));
    end

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
